// File: rtl/serial_bus_master_port.sv
// Bit-serial bus initiator: one host read/write becomes a header cycle plus MSB-first address/data bits;
// read data is deserialised from the slave. Define SERIAL_MASTER_TIMEOUT_EN to bound the read wait.
module serial_bus_master_port #(
    parameter int N       = 8,
    parameter int ADN     = 12,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_wren,
    input  logic [ADN-1:0] req_addr,
    input  logic [N-1:0]   req_wdata,
    output logic           resp_valid,
    output logic [N-1:0]   resp_rdata,
    output logic           resp_err,
    output logic           bus_valid,
    output logic           bus_wren,
    output logic           bus_burst,
    output logic           bus_addr,
    output logic           bus_wdata,
    input  logic           bus_rvalid,
    input  logic           bus_rdata
);
    localparam int AW = $clog2(ADN) + 1;
    localparam int BW = $clog2(N) + 1;
    localparam logic [AW-1:0] AddrLast  = AW'(ADN - 1);
    localparam logic [AW-1:0] DataFirst = AW'(ADN - N);
    localparam logic [BW-1:0] BitLast   = BW'(N - 1);

    if (N > ADN || N < 2 || TIMEOUT < 1) begin : gBadParams
        $error("serial_bus_master_port: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, HDR, ADDR, WAIT_RD, RD_DATA, RESP, GAP} state_t;
    state_t state, stateNxt;

    logic [AW-1:0]  addrCnt, addrCntNxt;
    logic [BW-1:0]  bitCnt, bitCntNxt;
    logic           gapCnt, gapCntNxt;
    logic           wrenQ, wrenNxt;
    logic [ADN-1:0] addrSh, addrShNxt;
    logic [N-1:0]   dataSh, dataShNxt;
    logic [N-1:0]   rdSh, rdShNxt;
    logic           errNxt;
    logic           timeoutHit;
    logic           busAddrNxt, busWdataNxt;
    logic           busActNxt;
    logic [N-1:0]   respRdataNxt;

`ifdef SERIAL_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] ToLast = TW'(TIMEOUT - 1);
    logic [TW-1:0] toCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            toCnt <= '0;
        end else if (state == ADDR) begin
            toCnt <= '0;
        end else if (state == WAIT_RD || state == RD_DATA) begin
            toCnt <= toCnt + 1'b1;
        end
    end

    // Fires on the edge where the wait count reaches TIMEOUT; beats any rvalid on that edge.
    assign timeoutHit = (state == WAIT_RD || state == RD_DATA) && (toCnt == ToLast);
`else
    assign timeoutHit = 1'b0;
`endif

    always_comb begin
        stateNxt    = state;
        addrCntNxt  = addrCnt;
        bitCntNxt   = bitCnt;
        gapCntNxt   = gapCnt;
        wrenNxt     = wrenQ;
        addrShNxt   = addrSh;
        dataShNxt   = dataSh;
        rdShNxt     = rdSh;
        errNxt      = 1'b0;
        busAddrNxt  = 1'b0;
        busWdataNxt = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    stateNxt  = HDR;
                    addrShNxt = req_addr;
                    dataShNxt = req_wdata;
                    wrenNxt   = req_wren;
                end
            end
            HDR: begin
                stateNxt   = ADDR;
                addrCntNxt = '0;
            end
            ADDR: begin
                if (addrCnt == AddrLast) begin
                    stateNxt = wrenQ ? RESP : WAIT_RD;
                end else begin
                    addrCntNxt = addrCnt + 1'b1;
                end
            end
            WAIT_RD: begin
                if (timeoutHit) begin
                    stateNxt = RESP;
                    errNxt   = 1'b1;
                end else if (bus_rvalid) begin
                    stateNxt  = RD_DATA;
                    bitCntNxt = '0;
                end
            end
            RD_DATA: begin
                if (timeoutHit) begin
                    stateNxt = RESP;
                    errNxt   = 1'b1;
                end else if (bus_rvalid) begin
                    rdShNxt = {rdSh[N-2:0], bus_rdata};
                    if (bitCnt == BitLast) begin
                        stateNxt = RESP;
                    end else begin
                        bitCntNxt = bitCnt + 1'b1;
                    end
                end
            end
            RESP: begin
                stateNxt  = GAP;
                gapCntNxt = 1'b0;
            end
            GAP: begin
                if (gapCnt) begin
                    stateNxt = IDLE;
                end else begin
                    gapCntNxt = 1'b1;
                end
            end
            default: stateNxt = IDLE;
        endcase

        // Outputs are registered, so the serial bits are chosen for the ADDR cycle about to begin.
        if (stateNxt == ADDR) begin
            busAddrNxt = addrShNxt[ADN-1];
            addrShNxt  = {addrShNxt[ADN-2:0], 1'b0};
            if (wrenNxt && addrCntNxt >= DataFirst) begin
                busWdataNxt = dataShNxt[N-1];
                dataShNxt   = {dataShNxt[N-2:0], 1'b0};
            end
        end

        busActNxt    = (stateNxt == HDR) || (stateNxt == ADDR);
        respRdataNxt = (wrenQ || errNxt) ? '0 : rdShNxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addrCnt    <= '0;
            bitCnt     <= '0;
            gapCnt     <= 1'b0;
            wrenQ      <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            bus_valid  <= 1'b0;
            bus_wren   <= 1'b0;
            bus_addr   <= 1'b0;
            bus_wdata  <= 1'b0;
        end else begin
            state      <= stateNxt;
            addrCnt    <= addrCntNxt;
            bitCnt     <= bitCntNxt;
            gapCnt     <= gapCntNxt;
            wrenQ      <= wrenNxt;
            req_ready  <= (stateNxt == IDLE);
            resp_valid <= (stateNxt == RESP);
            if (stateNxt == RESP) begin
                resp_rdata <= respRdataNxt;
                resp_err   <= errNxt;
            end
            bus_valid  <= busActNxt;
            bus_wren   <= busActNxt && wrenNxt;
            bus_addr   <= busAddrNxt;
            bus_wdata  <= busWdataNxt;
        end
    end

    always_ff @(posedge clk) begin
        addrSh <= addrShNxt;
        dataSh <= dataShNxt;
        rdSh   <= rdShNxt;
    end

    assign bus_burst = 1'b0;

endmodule

// File: tb/tb_serial_bus_master_port.sv
// Directed bench for serial_bus_master_port with a behavioural serial memory slave.
// Timeout scenario is included when SERIAL_MASTER_TIMEOUT_EN is defined.
module tb_serial_bus_master_port;
    localparam int N       = 8;
    localparam int ADN     = 12;
    localparam int TIMEOUT = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    logic           req_wren;
    logic [ADN-1:0] req_addr;
    logic [N-1:0]   req_wdata;
    logic           resp_valid;
    logic [N-1:0]   resp_rdata;
    logic           resp_err;
    logic           bus_valid;
    logic           bus_wren;
    logic           bus_burst;
    logic           bus_addr;
    logic           bus_wdata;
    logic           bus_rvalid;
    logic           bus_rdata;

    serial_bus_master_port #(.N(N), .ADN(ADN), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wren   (req_wren),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .bus_valid  (bus_valid),
        .bus_wren   (bus_wren),
        .bus_burst  (bus_burst),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural slave: header, 12 address/data bits, then load cycle and MSB-first read bits.
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LOAD, S_DATA} sst_t;
    sst_t           sSt;
    int             sCnt;
    int             sBits;
    int             sStall;
    logic           sWr;
    logic [11:0]    sA;
    logic [11:0]    sD;
    logic [7:0]     sWord;
    logic [7:0]     mem [0:4095];
    int             stallAt  = 99;
    int             stallLen = 0;
    logic           slaveMute = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            sSt        <= S_IDLE;
            bus_rvalid <= 1'b0;
            bus_rdata  <= 1'b0;
        end else begin
            case (sSt)
                S_IDLE: begin
                    bus_rvalid <= 1'b0;
                    if (bus_valid) begin
                        sSt  <= S_ADDR;
                        sCnt <= 0;
                        sWr  <= bus_wren;
                    end
                end
                S_ADDR: begin
                    sA   <= {sA[10:0], bus_addr};
                    sD   <= {sD[10:0], bus_wdata};
                    sCnt <= sCnt + 1;
                    if (sCnt == 11) begin
                        if (sWr) begin
                            mem[{sA[10:0], bus_addr}] <= {sD[6:0], bus_wdata};
                            sSt <= S_IDLE;
                        end else begin
                            sWord <= mem[{sA[10:0], bus_addr}];
                            sSt   <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (!slaveMute) begin
                        bus_rvalid <= 1'b1;
                        bus_rdata  <= 1'b1;
                        sBits      <= 0;
                        sStall     <= 0;
                        sSt        <= S_DATA;
                    end
                end
                default: begin
                    if (sBits == stallAt && sStall < stallLen) begin
                        bus_rvalid <= 1'b0;
                        sStall     <= sStall + 1;
                    end else if (sBits == 8) begin
                        bus_rvalid <= 1'b0;
                        sSt        <= S_IDLE;
                    end else begin
                        bus_rvalid <= 1'b1;
                        bus_rdata  <= sWord[7 - sBits];
                        sBits      <= sBits + 1;
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request; lat is the cycle index (accept edge = 0) at which resp_valid is seen.
    task automatic doReq(input logic wr, input logic [11:0] a, input logic [7:0] d,
                         output int lat, output logic [7:0] rd, output logic er,
                         output logic [11:0] sa, output logic [11:0] sw, output int vcnt);
        int w;
        w = 0;
        while (!req_ready && w < 100) begin
            tick();
            w++;
        end
        req_valid = 1'b1;
        req_wren  = wr;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
        lat = 0; rd = '0; er = 1'b0; sa = '0; sw = '0; vcnt = 0;
        for (int j = 1; j < 400; j++) begin
            if (bus_valid) vcnt++;
            if (j >= 2 && j <= ADN + 1) begin
                sa = {sa[10:0], bus_addr};
                sw = {sw[10:0], bus_wdata};
            end
            if (resp_valid) begin
                lat = j;
                rd  = resp_rdata;
                er  = resp_err;
                break;
            end
            tick();
        end
    endtask

    // Cycle index at which req_ready returns, plus any bus activity seen meanwhile.
    task automatic waitReady(input int from, output int at, output int busSeen);
        at = from;
        busSeen = 0;
        while (!req_ready && at < from + 50) begin
            tick();
            at++;
            if (bus_valid || bus_addr || bus_wdata || bus_wren) busSeen++;
        end
    endtask

    int          lat, vc, rdyAt, busSeen, nAcc, vRise, vHigh, respCnt;
    int          accAt [2];
    logic        prevV;
    logic [7:0]  rd;
    logic        er;
    logic [11:0] sa, sw;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_wren = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkVal("rst_req_ready", req_ready, 1);
        checkVal("rst_resp_valid", resp_valid, 0);
        checkVal("rst_resp_rdata", resp_rdata, 0);
        checkVal("rst_resp_err", resp_err, 0);
        checkVal("rst_bus", {bus_valid, bus_wren, bus_burst, bus_addr, bus_wdata}, 0);

        // Write 0x3C to 0x0A5
        doReq(1'b1, 12'h0A5, 8'h3C, lat, rd, er, sa, sw, vc);
        checkVal("wr_lat", lat, 14);
        checkVal("wr_bus_addr", sa, 12'h0A5);
        checkVal("wr_bus_wdata", sw, 12'h03C);
        checkVal("wr_valid_cycles", vc, 13);
        checkVal("wr_rdata_zero", rd, 0);
        waitReady(lat, rdyAt, busSeen);
        checkVal("wr_ready_at", rdyAt, 17);
        checkVal("wr_gap_bus_idle", busSeen, 0);

        // Read back through the slave
        doReq(1'b0, 12'h0A5, 8'h00, lat, rd, er, sa, sw, vc);
        checkVal("rd_lat", lat, 24);
        checkVal("rd_data", rd, 8'h3C);
        checkVal("rd_err", er, 0);
        checkVal("rd_addr_bits", sa, 12'h0A5);
        waitReady(lat, rdyAt, busSeen);
        checkVal("rd_rdata_held", resp_rdata, 8'h3C);

        // Read with 3 stall cycles after 4 data bits
        doReq(1'b1, 12'h123, 8'hA7, lat, rd, er, sa, sw, vc);
        checkVal("wr2_lat", lat, 14);
        waitReady(lat, rdyAt, busSeen);
        stallAt = 4; stallLen = 3;
        doReq(1'b0, 12'h123, 8'h00, lat, rd, er, sa, sw, vc);
        checkVal("stall_lat", lat, 27);
        checkVal("stall_data", rd, 8'hA7);
        waitReady(lat, rdyAt, busSeen);
        stallAt = 99; stallLen = 0;

        // Back-to-back writes with req_valid held high
        nAcc = 0; vRise = 0; vHigh = 0; prevV = 1'b0;
        accAt[0] = -1; accAt[1] = -1;
        req_wren = 1'b1; req_addr = 12'h3F0; req_wdata = 8'h5E; req_valid = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if (req_valid && req_ready && nAcc < 2) begin
                accAt[nAcc] = k;
                nAcc++;
            end
            tick();
            if (nAcc == 1) begin
                req_addr  = 12'h00F;
                req_wdata = 8'hC3;
            end
            if (nAcc == 2) req_valid = 1'b0;
            if (bus_valid && !prevV) vRise++;
            if (bus_valid) vHigh++;
            prevV = bus_valid;
        end
        req_valid = 1'b0;
        checkVal("b2b_accepts", nAcc, 2);
        checkVal("b2b_spacing", accAt[1] - accAt[0], ADN + 5);
        checkVal("b2b_valid_bursts", vRise, 2);
        checkVal("b2b_valid_cycles", vHigh, 26);
        doReq(1'b0, 12'h3F0, 8'h00, lat, rd, er, sa, sw, vc);
        checkVal("b2b_rd1", rd, 8'h5E);
        waitReady(lat, rdyAt, busSeen);
        doReq(1'b0, 12'h00F, 8'h00, lat, rd, er, sa, sw, vc);
        checkVal("b2b_rd2", rd, 8'hC3);
        waitReady(lat, rdyAt, busSeen);

        // Reset in the middle of a write's address phase
        req_valid = 1'b1; req_wren = 1'b1; req_addr = 12'h0A5; req_wdata = 8'h3C;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        checkVal("mid_in_addr", bus_valid, 1);
        reset = 1'b1;
        tick();
        checkVal("mid_rst_bus", {bus_valid, bus_wren, bus_burst, bus_addr, bus_wdata}, 0);
        checkVal("mid_rst_ready", req_ready, 1);
        checkVal("mid_rst_resp", resp_valid, 0);
        reset = 1'b0;
        respCnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (resp_valid) respCnt++;
        end
        checkVal("mid_no_resp", respCnt, 0);
        checkVal("mid_idle_ready", req_ready, 1);

`ifdef SERIAL_MASTER_TIMEOUT_EN
        // Slave never answers: timeout response
        slaveMute = 1'b1;
        doReq(1'b0, 12'h0A5, 8'h00, lat, rd, er, sa, sw, vc);
        checkVal("to_lat", lat, ADN + TIMEOUT + 2);
        checkVal("to_err", er, 1);
        checkVal("to_rdata", rd, 0);
        waitReady(lat, rdyAt, busSeen);
        checkVal("to_ready_at", rdyAt, ADN + TIMEOUT + 5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
